// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory/cache port between instruction
// fetch (I-side, read-only) and the data stage (D-side, read/write).
// Fixed D-over-I priority with a streak limit so fetch is never starved.
// Transactions run IDLE -> ISSUE -> WAIT -> DONE with a one-cycle strobe
// and a one-cycle ack back to the owning requester.
//
// Optional build macro: ARB_TIMEOUT_EN -- bounds WAIT to TIMEOUT cycles and
// completes with err=1 and rdata=0 when the bus never answers.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_req/i_addr              fetch request and address
//   i_ack/i_rdata             fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata data request, direction, address, store data
//   d_ack/d_rdata             data completion pulse and load data
//   p_strobe/p_rw/p_addr/p_wdata  registered bus request
//   p_rdata/p_ready           bus response
//   err                       timeout flag, coincident with the ack
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              p_strobe,
    output logic              p_rw,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic              p_ready,
    output logic              err
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    // Elaboration-time parameter range guards
    if ((MAX_D_STREAK < 1) || (MAX_D_STREAK > 15)) begin : g_bad_streak
        $error("mem_bus_arbiter: MAX_D_STREAK must be 1..15");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t              state, state_next;
    owner_t              owner, owner_next;
    logic [STREAK_W-1:0] streak, streak_next;
    logic [ADDR_W-1:0]   addr_next;
    logic [DATA_W-1:0]   wdata_next;
    logic                rw_next;
    logic [DATA_W-1:0]   i_rdata_next, d_rdata_next;
    logic                strobe_next, i_ack_next, d_ack_next, err_next;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt, tmo_cnt_next;
`endif

    // Next-state, arbitration and next-output logic
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        streak_next  = streak;
        addr_next    = p_addr;
        wdata_next   = p_wdata;
        rw_next      = p_rw;
        i_rdata_next = i_rdata;
        d_rdata_next = d_rdata;
        strobe_next  = 1'b0;
        i_ack_next   = 1'b0;
        d_ack_next   = 1'b0;
        err_next     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_next = tmo_cnt;
`endif
        case (state)
            S_IDLE: begin
                // D wins unless I is waiting and D has used up its streak
                if (d_req && !(i_req && (streak == STREAK_MAX))) begin
                    state_next  = S_ISSUE;
                    owner_next  = OWN_D;
                    streak_next = i_req ? streak + STREAK_W'(1) : '0;
                    addr_next   = d_addr;
                    wdata_next  = d_wdata;
                    rw_next     = d_we;
                    strobe_next = 1'b1;
                end else if (i_req) begin
                    state_next  = S_ISSUE;
                    owner_next  = OWN_I;
                    streak_next = '0;
                    addr_next   = i_addr;
                    rw_next     = 1'b0;
                    strobe_next = 1'b1;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_next = '0;
`endif
            end
            S_WAIT: begin
                if (p_ready) begin
                    state_next = S_DONE;
                    i_ack_next = (owner == OWN_I);
                    d_ack_next = (owner == OWN_D);
                    if (owner == OWN_I) i_rdata_next = p_rdata;
                    if (owner == OWN_D) d_rdata_next = p_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                // A late p_ready on the limit cycle takes the branch above
                else if (tmo_cnt == TMO_LAST) begin
                    state_next = S_DONE;
                    i_ack_next = (owner == OWN_I);
                    d_ack_next = (owner == OWN_D);
                    err_next   = 1'b1;
                    if (owner == OWN_I) i_rdata_next = '0;
                    if (owner == OWN_D) d_rdata_next = '0;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'd1;
                end
`endif
            end
            S_DONE: begin
                state_next = S_IDLE;
                owner_next = OWN_NONE;
            end
            default: begin
                state_next = S_IDLE;
                owner_next = OWN_NONE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= OWN_NONE;
            streak   <= '0;
            p_strobe <= 1'b0;
            p_rw     <= 1'b0;
            p_addr   <= '0;
            p_wdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            streak   <= streak_next;
            p_strobe <= strobe_next;
            p_rw     <= rw_next;
            p_addr   <= addr_next;
            p_wdata  <= wdata_next;
            i_ack    <= i_ack_next;
            d_ack    <= d_ack_next;
            i_rdata  <= i_rdata_next;
            d_rdata  <= d_rdata_next;
            err      <= err_next;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt  <= tmo_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAXS   = 4;
    localparam int unsigned TMO    = 8;
    localparam int          RND_CYCLES = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req, d_req, d_we, p_ready;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] d_wdata, p_rdata;
    logic              i_ack, d_ack, p_strobe, p_rw, err;
    logic [DATA_W-1:0] i_rdata, d_rdata, p_wdata;
    logic [ADDR_W-1:0] p_addr;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .p_strobe(p_strobe), .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_strobe"}, 64'(p_strobe), 64'd0);
        chk({name, "_iack"},   64'(i_ack),    64'd0);
        chk({name, "_dack"},   64'(d_ack),    64'd0);
        chk({name, "_rw"},     64'(p_rw),     64'd0);
        chk({name, "_addr"},   64'(p_addr),   64'd0);
        chk({name, "_wdata"},  64'(p_wdata),  64'd0);
        chk({name, "_irdata"}, 64'(i_rdata),  64'd0);
        chk({name, "_drdata"}, 64'(d_rdata),  64'd0);
        chk({name, "_err"},    64'(err),      64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; p_ready = 1'b0; rst = 1'b1;
        #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Directed vector: one transaction from IDLE; cycle 0 = request cycle
    typedef struct {
        bit          ireq;
        bit          dreq;
        bit          we;
        bit          noise;    // p_ready also pulsed in ISSUE and DONE
        bit          drop;     // requests withdrawn during WAIT
        logic [15:0] iaddr;
        logic [15:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;      // p_ready asserted in cycle 1+dly
        bit          exp_d;
        logic [15:0] exp_addr;
        bit          exp_rw;
        int          ack_cyc;
    } vec_t;

    function automatic vec_t mkv(bit ireq, bit dreq, bit we, bit noise, bit drop,
                                 logic [15:0] iaddr, logic [15:0] daddr,
                                 logic [31:0] wdata, logic [31:0] rdata, int dly,
                                 bit exp_d, logic [15:0] exp_addr, bit exp_rw,
                                 int ack_cyc);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.we = we; v.noise = noise; v.drop = drop;
        v.iaddr = iaddr; v.daddr = daddr; v.wdata = wdata; v.rdata = rdata;
        v.dly = dly; v.exp_d = exp_d; v.exp_addr = exp_addr; v.exp_rw = exp_rw;
        v.ack_cyc = ack_cyc;
        return v;
    endfunction

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input bit do_rst);
        if (do_rst) do_reset();
        @(posedge clk); #1;
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_we = v.we; d_addr = v.daddr; d_wdata = v.wdata;
        p_ready = 1'b0;
        @(negedge clk);
        chk("vec_strobe_c0", 64'(p_strobe), 64'd0);
        for (int c = 1; c <= v.ack_cyc + 1; c++) begin
            @(posedge clk); #1;
            if (v.drop && c == 2) begin i_req = 1'b0; d_req = 1'b0; end
            if (c == v.ack_cyc + 1) begin i_req = 1'b0; d_req = 1'b0; end
            p_ready = (c == 1 + v.dly) || (v.noise && (c == 1 || c == v.ack_cyc));
            p_rdata = (c == 1 + v.dly) ? v.rdata : $urandom;
            @(negedge clk);
            chk("vec_strobe", 64'(p_strobe), 64'(c == 1));
            if (c <= v.ack_cyc) begin
                chk("vec_addr", 64'(p_addr), 64'(v.exp_addr));
                chk("vec_rw",   64'(p_rw),   64'(v.exp_rw));
                if (v.exp_d && v.we) chk("vec_wdata", 64'(p_wdata), 64'(v.wdata));
            end
            chk("vec_dack", 64'(d_ack), 64'(c == v.ack_cyc && v.exp_d));
            chk("vec_iack", 64'(i_ack), 64'(c == v.ack_cyc && !v.exp_d));
            chk("vec_err",  64'(err),   64'd0);
            if (c >= v.ack_cyc) begin
                if (v.exp_d) chk("vec_drdata", 64'(d_rdata), 64'(v.rdata));
                else         chk("vec_irdata", 64'(i_rdata), 64'(v.rdata));
            end
        end
        p_ready = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    // D read with WAIT of exactly TMO cycles; ready optionally on the last one
    task automatic tmo_seq(input bit give_ready, input logic [31:0] data);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0444; p_ready = 1'b0;
        for (int c = 1; c <= TMO + 3; c++) begin
            @(posedge clk); #1;
            if (c == TMO + 3) d_req = 1'b0;
            p_ready = give_ready && (c == TMO + 1);
            p_rdata = data;
            @(negedge clk);
            chk("tmo_dack", 64'(d_ack), 64'(c == TMO + 2));
            chk("tmo_err",  64'(err),   64'(c == TMO + 2 && !give_ready));
            if (c == TMO + 2)
                chk("tmo_rdata", 64'(d_rdata), give_ready ? 64'(data) : 64'd0);
        end
        p_ready = 1'b0;
    endtask
`endif

    // Starvation sequence expectations: four D grants, then I, then D again
    bit          st_side[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] st_addr[6] = '{16'h0D00, 16'h0D00, 16'h0D00, 16'h0D00, 16'h0100, 16'h0D00};
    bit          st_rw[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit          ack_q[$];
    int          ackc_q[$];
    logic [15:0] sa_q[$];
    bit          srw_q[$];

    // Reference model state for the random run
    int unsigned m_streak;
    bit          m_busy, m_exp_d, m_exp_rw, m_ack_d;
    logic [15:0] m_exp_addr;
    logic [31:0] m_exp_wdata, m_ack_data, bus_data;
    int          m_strobe_at, m_ack_at, m_free_at, ready_at;
    bit          bus_pend, saw_i_ack, saw_d_ack;

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; p_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; p_rdata = '0;
        @(negedge clk);
        check_zero("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // ireq dreq we noise drop iaddr daddr wdata rdata dly | exp_d addr rw ack
        vecs[0] = mkv(0, 1, 0, 0, 0, 16'h0000, 16'h0040, 32'h0, 32'h1234_5678, 1,
                      1, 16'h0040, 0, 3);
        vecs[1] = mkv(1, 1, 1, 0, 0, 16'h0200, 16'h0300, 32'hA5A5_5A5A, 32'h0BAD_BEEF, 2,
                      1, 16'h0300, 1, 4);
        vecs[2] = mkv(1, 0, 1, 0, 0, 16'h1234, 16'h0999, 32'h0, 32'hDEAD_0001, 3,
                      0, 16'h1234, 0, 5);
        vecs[3] = mkv(0, 1, 1, 0, 0, 16'h0000, 16'h0080, 32'hCAFE_F00D, 32'h0000_5555, 5,
                      1, 16'h0080, 1, 7);
        vecs[4] = mkv(1, 0, 0, 1, 0, 16'hFFFF, 16'h0000, 32'h0, 32'h7777_0000, 2,
                      0, 16'hFFFF, 0, 4);
        vecs[5] = mkv(0, 1, 0, 0, 1, 16'h0000, 16'h00F0, 32'h0, 32'h0101_0101, 4,
                      1, 16'h00F0, 0, 6);
        vecs[6] = mkv(1, 1, 1, 0, 0, 16'h0000, 16'hFFFE, 32'hFFFF_FFFF, 32'h8000_0001, 1,
                      1, 16'hFFFE, 1, 3);
        for (int k = 0; k < 7; k++) run_vec(vecs[k], 1'b1);

        // Reset while in WAIT: outputs clear at once, nothing completes
        do_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_strobe", 64'(p_strobe), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_addr_before", 64'(p_addr), 64'h0100);
        #2;
        rst = 1'b1; d_req = 1'b0;
        #1;
        check_zero("rst_in_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            p_ready = 1'b1; p_rdata = $urandom;
            @(negedge clk);
            chk("rstw_no_strobe", 64'(p_strobe), 64'd0);
            chk("rstw_no_ack",    64'({i_ack, d_ack}), 64'd0);
        end
        p_ready = 1'b0;
        run_vec(vecs[0], 1'b0);

        // Starvation guard: D held high while I waits
        do_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0D00; d_wdata = 32'h1111_2222;
        i_req = 1'b1; i_addr = 16'h0100;
        begin
            bit rdy_next;
            bit i_seen;
            rdy_next = 1'b0;
            i_seen = 1'b0;
            for (int c = 1; c <= 80 && ack_q.size() < 6; c++) begin
                @(posedge clk); #1;
                if (i_seen) i_req = 1'b0;
                p_ready = rdy_next;
                p_rdata = 32'(c);
                @(negedge clk);
                rdy_next = p_strobe;
                if (p_strobe) begin sa_q.push_back(p_addr); srw_q.push_back(p_rw); end
                if (d_ack || i_ack) begin ack_q.push_back(d_ack); ackc_q.push_back(c); end
                chk("starve_one_ack", 64'(d_ack && i_ack), 64'd0);
                i_seen = i_ack;
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0; i_req = 1'b0; p_ready = 1'b0;
        chk("starve_ack_count", 64'(ack_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < ack_q.size(); k++) begin
            chk("starve_side", 64'(ack_q[k]), 64'(st_side[k]));
            if (k > 0) chk("starve_gap", 64'(ackc_q[k] - ackc_q[k-1]), 64'd4);
        end
        for (int k = 0; k < 6 && k < sa_q.size(); k++) begin
            chk("starve_addr", 64'(sa_q[k]), 64'(st_addr[k]));
            chk("starve_rw",   64'(srw_q[k]), 64'(st_rw[k]));
        end

`ifdef ARB_TIMEOUT_EN
        do_reset();
        tmo_seq(1'b1, 32'h600D_0008);
        tmo_seq(1'b0, 32'h0BAD_0008);
`endif

        // Randomized traffic against the transaction-level model
        do_reset();
        m_streak = 0; m_busy = 1'b0; m_strobe_at = -1; m_ack_at = -1; m_free_at = 0;
        bus_pend = 1'b0; saw_i_ack = 1'b0; saw_d_ack = 1'b0; ready_at = -1;
        m_exp_d = 1'b0; m_exp_rw = 1'b0; m_ack_d = 1'b0;
        m_exp_addr = '0; m_exp_wdata = '0; m_ack_data = '0; bus_data = '0;
        for (int c = 0; c < RND_CYCLES; c++) begin
            @(posedge clk);
            // Model consumes the inputs that were present during cycle c-1
            if (m_busy && p_ready && (c - 1 > m_strobe_at)) begin
                m_busy = 1'b0; m_ack_at = c; m_ack_d = m_exp_d;
                m_ack_data = p_rdata; m_free_at = c + 2;
            end else if (!m_busy && c >= m_free_at) begin
                if (d_req && !(i_req && m_streak == MAXS)) begin
                    m_busy = 1'b1; m_strobe_at = c; m_exp_d = 1'b1;
                    m_streak = i_req ? m_streak + 1 : 0;
                    m_exp_addr = d_addr; m_exp_rw = d_we; m_exp_wdata = d_wdata;
                end else if (i_req) begin
                    m_busy = 1'b1; m_strobe_at = c; m_exp_d = 1'b0;
                    m_streak = 0; m_exp_addr = i_addr; m_exp_rw = 1'b0;
                end
            end
            #1;
            if (saw_d_ack) d_req = 1'b0;
            if (saw_i_ack) i_req = 1'b0;
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom);
                d_wdata = $urandom;
            end
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom);
            end
            p_ready = 1'b0;
            p_rdata = $urandom;
            if (bus_pend && c == ready_at) begin
                p_ready = 1'b1; p_rdata = bus_data; bus_pend = 1'b0;
            end
            @(negedge clk);
            chk("rnd_strobe", 64'(p_strobe), 64'(c == m_strobe_at));
            if (m_busy || c == m_ack_at) begin
                chk("rnd_addr", 64'(p_addr), 64'(m_exp_addr));
                chk("rnd_rw",   64'(p_rw),   64'(m_exp_rw));
                if (m_exp_rw) chk("rnd_wdata", 64'(p_wdata), 64'(m_exp_wdata));
            end
            chk("rnd_dack", 64'(d_ack), 64'(c == m_ack_at && m_ack_d));
            chk("rnd_iack", 64'(i_ack), 64'(c == m_ack_at && !m_ack_d));
            chk("rnd_err",  64'(err),   64'd0);
            if (c == m_ack_at) begin
                if (m_ack_d) chk("rnd_drdata", 64'(d_rdata), 64'(m_ack_data));
                else         chk("rnd_irdata", 64'(i_rdata), 64'(m_ack_data));
            end
            if (p_strobe) begin
                bus_pend = 1'b1;
                ready_at = c + int'($urandom_range(1, 4));
                bus_data = $urandom;
            end
            saw_d_ack = d_ack;
            saw_i_ack = i_ack;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
